// File: rtl/alu_pkg.sv
// Shared opcode constants, controller state encoding and opcode check.
package alu_pkg;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;

  // True only for the eight opcodes the ALU implements.
  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRL, OP_SRA: op_supported = 1'b1;
      default:                        op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU; all results truncated to N_BITS (carry/borrow dropped).
// Shifts move operand a right by the amount held in operand b.
module alu
  import alu_pkg::*;
#(
  parameter int N_BITS = 8
) (
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  input  logic [5:0]        op,
  output logic [N_BITS-1:0] y
);

  // Opcode decode to result; unknown opcodes yield zero.
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_SRL:  y = a >> b;
      OP_SRA:  y = N_BITS'($signed(a) >>> b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/btn_pulse.sv
// Two-flop edge detector: one-cycle pulse per rising edge of a debounced level.
module btn_pulse (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic btn_q, btn_qq;

  // Sample the button and keep one cycle of history; both clear on reset so a
  // button held through reset release still yields a single pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q  <= 1'b0;
      btn_qq <= 1'b0;
    end else begin
      btn_q  <= btn;
      btn_qq <= btn_q;
    end
  end

  assign pulse = btn_q & ~btn_qq;

endmodule

// File: rtl/alu_ctrl.sv
// Button-driven ALU front end: load A, B, opcode from shared switches, run
// one EXEC cycle and hold the registered result until a new A is loaded.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int N_BITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BITS-1:0] sw,
  input  logic              btn_a,
  input  logic              btn_b,
  input  logic              btn_op,
  output logic [N_BITS-1:0] result,
  output logic              valid,
  output logic              op_err,
  output logic [2:0]        state
);

  state_t            state_r, state_nx;
  logic [N_BITS-1:0] a_r, b_r, alu_y;
  logic [5:0]        op_r;
  logic              pa, pb, po;
  logic              ld_a, ld_b, ld_op, set_err, do_exec;

  btn_pulse u_pa (.clk(clk), .reset(reset), .btn(btn_a),  .pulse(pa));
  btn_pulse u_pb (.clk(clk), .reset(reset), .btn(btn_b),  .pulse(pb));
  btn_pulse u_po (.clk(clk), .reset(reset), .btn(btn_op), .pulse(po));

  alu #(.N_BITS(N_BITS)) u_alu (.a(a_r), .b(b_r), .op(op_r), .y(alu_y));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= WAIT_A;
    else       state_r <= state_nx;
  end

  // Next state and load strobes; only the current state's own button acts,
  // so stray or simultaneous pulses fall through with no effect.
  always_comb begin
    state_nx = state_r;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    ld_op    = 1'b0;
    set_err  = 1'b0;
    do_exec  = 1'b0;
    case (state_r)
      WAIT_A, DONE: if (pa) begin
        ld_a     = 1'b1;
        state_nx = WAIT_B;
      end
      WAIT_B: if (pb) begin
        ld_b     = 1'b1;
        state_nx = WAIT_OP;
      end
      WAIT_OP: if (po) begin
        if (op_supported(sw[5:0])) begin
          ld_op    = 1'b1;
          state_nx = EXEC;
        end else begin
          set_err  = 1'b1;
        end
      end
      EXEC: begin
        do_exec  = 1'b1;
        state_nx = DONE;
      end
      default: state_nx = WAIT_A;
    endcase
  end

  // Operand/opcode registers and registered result; reset wins over any
  // strobe, discarding an in-flight EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= OP_ADD;
      result <= '0;
      valid  <= 1'b0;
      op_err <= 1'b0;
    end else begin
      if (ld_a) begin
        a_r   <= sw;
        valid <= 1'b0;
      end
      if (ld_b) b_r <= sw;
      if (ld_op) begin
        op_r   <= sw[5:0];
        op_err <= 1'b0;
      end
      if (set_err) op_err <= 1'b1;
      if (do_exec) begin
        result <= alu_y;
        valid  <= 1'b1;
      end
    end
  end

  assign state = state_r;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: vector table through a result scoreboard, plus
// hand-written sequences for latency, ignored buttons, held buttons and reset.
module tb_alu_ctrl;
  import alu_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] sw = '0;
  logic         btn_a = 1'b0, btn_b = 1'b0, btn_op = 1'b0;
  logic [N-1:0] result;
  logic         valid, op_err;
  logic [2:0]   state;

  int nvec = 0;
  int nerr = 0;
  logic [N-1:0] sb[$];
  logic vprev = 1'b0;

  alu_ctrl #(.N_BITS(N)) dut (
    .clk(clk), .reset(reset), .sw(sw),
    .btn_a(btn_a), .btn_b(btn_b), .btn_op(btn_op),
    .result(result), .valid(valid), .op_err(op_err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [5:0]   op;
    logic [N-1:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each rising edge of valid must match the oldest queued result.
  always @(negedge clk) begin
    if (!reset && valid && !vprev) begin
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL sb_unexpected: got result %0h with nothing expected", result);
      end else begin
        chk("sb_result", {24'd0, result}, {24'd0, sb.pop_front()});
      end
    end
    vprev = valid;
  end

  task automatic press(input int which);
    @(negedge clk);
    case (which)
      0: btn_a = 1'b1;
      1: btn_b = 1'b1;
      default: btn_op = 1'b1;
    endcase
    repeat (2) @(negedge clk);
    btn_a = 1'b0; btn_b = 1'b0; btn_op = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("valid_timeout", {31'd0, valid}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [5:0] op, input logic [N-1:0] exp);
    sw = a; press(0);
    chk("valid_drop_on_a", {31'd0, valid}, 32'd0);
    sw = b; press(1);
    sw = {2'b00, op};
    sb.push_back(exp);
    press(2);
    wait_valid();
    chk("state_done", {29'd0, state}, 32'd4);
    chk("op_err_clear", {31'd0, op_err}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{8'h04, 8'h01, OP_SUB, 8'h03};
    vecs[1]  = '{8'h00, 8'h01, OP_SUB, 8'hFF};
    vecs[2]  = '{8'hFE, 8'hFE, OP_NOR, 8'h01};
    vecs[3]  = '{8'h03, 8'h02, OP_AND, 8'h02};
    vecs[4]  = '{8'h04, 8'h03, OP_OR,  8'h07};
    vecs[5]  = '{8'h03, 8'h01, OP_XOR, 8'h02};
    vecs[6]  = '{8'hF0, 8'h20, OP_ADD, 8'h10};
    vecs[7]  = '{8'h80, 8'h01, OP_SRA, 8'hC0};
    vecs[8]  = '{8'h80, 8'h01, OP_SRL, 8'h40};
    vecs[9]  = '{8'h40, 8'h02, OP_SRA, 8'h10};
    vecs[10] = '{8'h0F, 8'h0A, OP_ADD, 8'h19};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_state",  {29'd0, state}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_valid",  {31'd0, valid}, 32'd0);
    chk("rst_op_err", {31'd0, op_err}, 32'd0);
    reset = 1'b0;

    // 1 + 1 with exact latency: btn_op sampled at e0, EXEC after e1, valid after e2.
    sw = 8'd1; press(0);
    press(1);
    sw = {2'b00, OP_ADD};
    sb.push_back(8'd2);
    @(negedge clk); btn_op = 1'b1;
    @(negedge clk);
    chk("lat_e0_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    chk("lat_e1_state", {29'd0, state}, 32'd3);
    chk("lat_e1_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    chk("lat_e2_valid", {31'd0, valid}, 32'd1);
    chk("lat_e2_state", {29'd0, state}, 32'd4);
    btn_op = 1'b0;
    repeat (2) @(negedge clk);
    chk("done_hold", {24'd0, result}, 32'd2);

    // Table of operations, chained from DONE.
    for (int i = 0; i < 11; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);

    // Wrong-state buttons are ignored; unsupported opcode flags op_err.
    do_reset();
    sw = 8'd5; press(0);
    sw = 8'h3F; press(2);
    chk("ign_op_state", {29'd0, state}, 32'd1);
    chk("ign_op_err",   {31'd0, op_err}, 32'd0);
    sw = 8'd9; press(0);
    chk("ign_a_state", {29'd0, state}, 32'd1);
    sw = 8'd3; press(1);
    sw = 8'h3F; press(2);
    chk("bad_op_err",   {31'd0, op_err}, 32'd1);
    chk("bad_op_state", {29'd0, state}, 32'd2);
    sw = {2'b00, OP_ADD};
    sb.push_back(8'd8);
    press(2);
    wait_valid();
    chk("good_op_err", {31'd0, op_err}, 32'd0);

    // Held btn_a: one load only, even after reaching DONE.
    do_reset();
    @(negedge clk); sw = 8'd7; btn_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold_state_b", {29'd0, state}, 32'd1);
    sw = 8'd2; press(1);
    sw = {2'b00, OP_ADD};
    sb.push_back(8'd9);
    press(2);
    wait_valid();
    repeat (8) @(negedge clk);
    chk("hold_still_done", {29'd0, state}, 32'd4);
    btn_a = 1'b0;

    // btn_a and btn_b on the same edge in WAIT_A: only A acts.
    do_reset();
    @(negedge clk); sw = 8'h0A; btn_a = 1'b1; btn_b = 1'b1;
    repeat (2) @(negedge clk);
    btn_a = 1'b0; btn_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("simul_state", {29'd0, state}, 32'd1);
    sw = 8'd1; press(1);
    sw = {2'b00, OP_ADD};
    sb.push_back(8'h0B);
    press(2);
    wait_valid();

    // Button held across reset release yields one pulse.
    @(negedge clk); reset = 1'b1; btn_a = 1'b1; sw = 8'h21;
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_held_btn", {29'd0, state}, 32'd1);
    btn_a = 1'b0;

    // Reset during EXEC discards the operation.
    do_reset();
    run_op(8'd6, 8'd6, OP_ADD, 8'd12);
    sw = 8'd1; press(0);
    press(1);
    sw = {2'b00, OP_SUB};
    @(negedge clk); btn_op = 1'b1;
    repeat (2) @(negedge clk);
    chk("exec_seen", {29'd0, state}, 32'd3);
    reset = 1'b1; btn_op = 1'b0;
    @(negedge clk);
    chk("exec_rst_state",  {29'd0, state}, 32'd0);
    chk("exec_rst_result", {24'd0, result}, 32'd0);
    chk("exec_rst_valid",  {31'd0, valid}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have parameter N_BITS, default 8, meaning operand/result width (N_BITS >= 6).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sw  input  N_BITS  shared data switches: operand A/B value, or opcode in sw[5:0].
REQ-005 SHALL have port btn_a  input  1  level, debounced; rising edge loads A.
REQ-006 SHALL have port btn_b  input  1  level, debounced; rising edge loads B.
REQ-007 SHALL have port btn_op  input  1  level, debounced; rising edge loads opcode.
REQ-008 SHALL have port result  output  N_BITS  registered ALU result.
REQ-009 SHALL have port valid  output  1  high while result holds the current operation's output.
REQ-010 SHALL have port op_err  output  1  high after an unsupported opcode was offered.
REQ-011 SHALL have port state  output  3  current FSM state encoding, for LED display.

Function
REQ-012 Each button SHALL be registered once (btn_q) and once more (btn_qq); press pulse = btn_q & ~btn_qq, high exactly one cycle per rising edge.
REQ-013 FSM states SHALL be WAIT_A(0), WAIT_B(1), WAIT_OP(2), EXEC(3), DONE(4).
REQ-014 WAIT_A: on btn_a pulse, A <= sw, valid <= 0, go WAIT_B.
REQ-015 WAIT_B: on btn_b pulse, B <= sw, go WAIT_OP.
REQ-016 WAIT_OP: on btn_op pulse with sw[5:0] supported, OP <= sw[5:0], op_err <= 0, go EXEC; unsupported: OP unchanged, op_err <= 1, stay WAIT_OP.
REQ-017 Supported opcodes SHALL be exactly ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111.
REQ-018 EXEC SHALL last exactly one cycle: result <= alu out(A, B, OP), valid <= 1, go DONE.
REQ-019 DONE: result and valid held; btn_a pulse behaves as in WAIT_A (new operation, valid drops the cycle A loads).
REQ-020 Pulses from buttons not matching the current state SHALL be ignored with no side effects.
REQ-021 Simultaneous pulses SHALL be resolved by state: only the state's own button acts.
REQ-022 Latency: btn_op first sampled high at edge e0 -> OP loaded at e1 -> result/valid updated at e2.
REQ-023 Arithmetic SHALL be modulo 2^N_BITS; carry/borrow discarded; result never sign-extended beyond N_BITS.
REQ-024 A held button SHALL produce no further pulses until released and re-pressed.

Reset
REQ-025 On reset high at a clock edge: state=WAIT_A, A=B=0, OP=ADD, result=0, valid=0, op_err=0, btn_q=btn_qq=0.
REQ-026 Reset SHALL override any pending pulse or EXEC in the same cycle; the interrupted operation is discarded.
REQ-027 A button already high when reset releases SHALL produce one pulse (btn_qq starts at 0).

Structure
REQ-028 Opcode constants and the state enum SHALL live in shared package alu_pkg, also used by alu.
REQ-029 Edge detection SHALL be one sub-module btn_pulse, instantiated three times.
REQ-030 alu_ctrl SHALL instantiate the existing alu with N_BITS passed through; operands and opcode taken from registers only.

Verification
REQ-031 Reset, sw=1, press a, press b, sw=100000, press op -> result=2, valid=1 two cycles after op edge, state=DONE.
REQ-032 A=4, B=1, opcode 100010 -> result=3; then A=0x00, B=0x01 SUB -> result=0xFF (wrap).
REQ-033 A=0xFE, B=0xFE, NOR -> result=0x01; AND 3,2 -> 2; OR 4,3 -> 7; XOR 3,1 -> 2.
REQ-034 In WAIT_B, sw=111111 press op, press a -> ignored; press b, then op with 111111 -> op_err=1, state stays WAIT_OP; then 100000 -> op_err=0, result valid.
REQ-035 Hold btn_a high 20 cycles in WAIT_A -> exactly one load; btn_a and btn_b same edge in WAIT_A -> only A loaded.
REQ-036 Assert reset the cycle state=EXEC -> next cycle state=WAIT_A, result=0, valid=0.
